// File: rtl/instruction_dispatch_pkg.sv
// Shared definitions for the dual-instruction dispatch block: opcodes, fetch-request
// encodings and the 32-bit {type,dest,src1,src2} instruction packing.
package instruction_dispatch_pkg;

   localparam int FW = 8;

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_MUL = 8'h02;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_ONE  = 2'b01;
   localparam logic [1:0] SEL_TWO  = 2'b10;

   typedef struct packed {
      logic [FW-1:0] op;
      logic [FW-1:0] dest;
      logic [FW-1:0] src1;
      logic [FW-1:0] src2;
   } inst_t;

   function automatic inst_t pack_inst(input logic [FW-1:0] op, input logic [FW-1:0] dest,
                                       input logic [FW-1:0] src1, input logic [FW-1:0] src2);
      inst_t r;
      r.op   = op;
      r.dest = dest;
      r.src1 = src1;
      r.src2 = src2;
      return r;
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// In-order instruction buffer with two write and two read ports per cycle; exposes the
// head and head+1 entries combinationally from registered storage.
module dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    wr_num_i,
   input  logic [W-1:0]  wr_data0_i,
   input  logic [W-1:0]  wr_data1_i,
   input  logic [1:0]    rd_num_i,
   output logic [W-1:0]  head_o,
   output logic [W-1:0]  head_next_o,
   output logic [CW-1:0] count_o
);
   import instruction_dispatch_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(wr_num_i);
         rd_ptr_q <= rd_ptr_q + AW'(rd_num_i);
         count_q  <= count_q + CW'(wr_num_i) - CW'(rd_num_i);
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (wr_num_i != 2'd0) mem_q[wr_ptr_q] <= wr_data0_i;
      if (wr_num_i == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= wr_data1_i;
   end

   assign head_o      = mem_q[rd_ptr_q];
   assign head_next_o = mem_q[rd_ptr_q + AW'(1)];
   assign count_o     = count_q;

endmodule

// File: rtl/instruction_dispatch.sv
// Buffers up to two fetched instructions per cycle and issues them in order to the ADD and
// MUL reservation stations, pairing head and head+1 when they target different stations.
module instruction_dispatch #(
   parameter int DEPTH = 4,
   parameter int FW    = instruction_dispatch_pkg::FW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inst1_valid,
   input  logic [FW-1:0] inst1_type,
   input  logic [FW-1:0] inst1_destination_reg,
   input  logic [FW-1:0] inst1_source_reg1,
   input  logic [FW-1:0] inst1_source_reg2,
   input  logic          inst2_valid,
   input  logic [FW-1:0] inst2_type,
   input  logic [FW-1:0] inst2_destination_reg,
   input  logic [FW-1:0] inst2_source_reg1,
   input  logic [FW-1:0] inst2_source_reg2,
   output logic [1:0]    select_instruction,
   output logic          add_issue_valid,
   input  logic          add_issue_ready,
   output logic [FW-1:0] add_issue_dest,
   output logic [FW-1:0] add_issue_src1,
   output logic [FW-1:0] add_issue_src2,
   output logic          mul_issue_valid,
   input  logic          mul_issue_ready,
   output logic [FW-1:0] mul_issue_dest,
   output logic [FW-1:0] mul_issue_src1,
   output logic [FW-1:0] mul_issue_src2,
   output logic          illegal_op,
   output logic          overflow_err,
   output logic [15:0]   issued_count
);
   import instruction_dispatch_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = 4 * FW;

   logic [IW-1:0] head, head_next, pk1, pk2, wr_data0;
   logic [CW-1:0] count, free_now, count_next, free_next;
   logic [1:0]    rd_num, wr_num, select_d, select_q;
   logic          head_vld, next_vld, head_add, head_mul, head_ill, head_xfer;
   logic          pair_add, pair_mul, add_fire, mul_fire, take1, take2, drop;
   logic          illegal_d, illegal_q, overflow_d, overflow_q;
   logic [16:0]   issued_sum;
   logic [15:0]   issued_d, issued_q;

   assign pk1 = {inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2};
   assign pk2 = {inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2};

   dispatch_fifo #(.DEPTH(DEPTH), .W(IW), .CW(CW)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_num_i   (wr_num),
      .wr_data0_i (wr_data0),
      .wr_data1_i (pk2),
      .rd_num_i   (rd_num),
      .head_o     (head),
      .head_next_o(head_next),
      .count_o    (count)
   );

   always_comb begin
      head_vld  = (count != '0);
      next_vld  = (count >= CW'(2));
      head_add  = head_vld && (head[IW-1 -: FW] == FW'(OP_ADD));
      head_mul  = head_vld && (head[IW-1 -: FW] == FW'(OP_MUL));
      head_ill  = head_vld && !head_add && !head_mul;
      head_xfer = (head_add && add_issue_ready) || (head_mul && mul_issue_ready);
      // head+1 may only ride along when the head leaves this cycle, so it can never overtake it
      pair_add  = head_mul && head_xfer && next_vld && (head_next[IW-1 -: FW] == FW'(OP_ADD));
      pair_mul  = head_add && head_xfer && next_vld && (head_next[IW-1 -: FW] == FW'(OP_MUL));

      add_issue_valid = head_add || pair_add;
      mul_issue_valid = head_mul || pair_mul;
      {add_issue_dest, add_issue_src1, add_issue_src2} = '0;
      {mul_issue_dest, mul_issue_src1, mul_issue_src2} = '0;
      if (head_add)      {add_issue_dest, add_issue_src1, add_issue_src2} = head[3*FW-1:0];
      else if (pair_add) {add_issue_dest, add_issue_src1, add_issue_src2} = head_next[3*FW-1:0];
      if (head_mul)      {mul_issue_dest, mul_issue_src1, mul_issue_src2} = head[3*FW-1:0];
      else if (pair_mul) {mul_issue_dest, mul_issue_src1, mul_issue_src2} = head_next[3*FW-1:0];

      add_fire = add_issue_valid && add_issue_ready;
      mul_fire = mul_issue_valid && mul_issue_ready;
      rd_num   = {1'b0, add_fire} + {1'b0, mul_fire} + {1'b0, head_ill};

      // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
      free_now = CW'(DEPTH) - count + CW'(rd_num);
      take1    = inst1_valid && (free_now != '0);
      take2    = inst2_valid && (free_now >= (take1 ? CW'(2) : CW'(1)));
      wr_num   = {1'b0, take1} + {1'b0, take2};
      wr_data0 = take1 ? pk1 : pk2;
      drop     = (inst1_valid && !take1) || (inst2_valid && !take2);

      count_next = count - CW'(rd_num) + CW'(wr_num);
      free_next  = CW'(DEPTH) - count_next;
      if (free_next >= CW'(2))      select_d = SEL_TWO;
      else if (free_next == CW'(1)) select_d = SEL_ONE;
      else                          select_d = SEL_NONE;

      illegal_d  = head_ill;
      overflow_d = overflow_q || drop;
      issued_sum = {1'b0, issued_q} + 17'(add_fire) + 17'(mul_fire);
      issued_d   = issued_sum[16] ? 16'hFFFF : issued_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         select_q   <= SEL_NONE;
         illegal_q  <= 1'b0;
         overflow_q <= 1'b0;
         issued_q   <= '0;
      end else begin
         select_q   <= select_d;
         illegal_q  <= illegal_d;
         overflow_q <= overflow_d;
         issued_q   <= issued_d;
      end
   end

   assign select_instruction = select_q;
   assign illegal_op         = illegal_q;
   assign overflow_err       = overflow_q;
   assign issued_count       = issued_q;

endmodule

// File: tb/tb_instruction_dispatch.sv
// Directed-vector bench for instruction_dispatch: each task drives one scenario and checks
// the issue ports, fetch request, error flags and issued count against hand-derived values.
module tb_instruction_dispatch;
   import instruction_dispatch_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inst1_valid, inst2_valid;
   logic [7:0] inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2;
   logic [7:0] inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2;
   logic [1:0] select_instruction;
   logic add_issue_valid, add_issue_ready, mul_issue_valid, mul_issue_ready;
   logic [7:0] add_issue_dest, add_issue_src1, add_issue_src2;
   logic [7:0] mul_issue_dest, mul_issue_src1, mul_issue_src2;
   logic illegal_op, overflow_err;
   logic [15:0] issued_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   instruction_dispatch #(.DEPTH(4), .FW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst1_valid(inst1_valid), .inst1_type(inst1_type),
      .inst1_destination_reg(inst1_destination_reg),
      .inst1_source_reg1(inst1_source_reg1), .inst1_source_reg2(inst1_source_reg2),
      .inst2_valid(inst2_valid), .inst2_type(inst2_type),
      .inst2_destination_reg(inst2_destination_reg),
      .inst2_source_reg1(inst2_source_reg1), .inst2_source_reg2(inst2_source_reg2),
      .select_instruction(select_instruction),
      .add_issue_valid(add_issue_valid), .add_issue_ready(add_issue_ready),
      .add_issue_dest(add_issue_dest), .add_issue_src1(add_issue_src1),
      .add_issue_src2(add_issue_src2),
      .mul_issue_valid(mul_issue_valid), .mul_issue_ready(mul_issue_ready),
      .mul_issue_dest(mul_issue_dest), .mul_issue_src1(mul_issue_src1),
      .mul_issue_src2(mul_issue_src2),
      .illegal_op(illegal_op), .overflow_err(overflow_err), .issued_count(issued_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v1, input inst_t i1, input logic v2, input inst_t i2);
      inst1_valid = v1;
      {inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2} = i1;
      inst2_valid = v2;
      {inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2} = i2;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0);
   endtask

   task automatic do_reset();
      idle();
      add_issue_ready = 1'b0;
      mul_issue_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      add_issue_ready = 1'b0;
      mul_issue_ready = 1'b0;
      tick();
      vectors++;
      if ({select_instruction, add_issue_valid, mul_issue_valid, illegal_op, overflow_err} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got sel=%b av=%b mv=%b ill=%b ovf=%b expected all 0",
                  select_instruction, add_issue_valid, mul_issue_valid, illegal_op, overflow_err);
      end
      vectors++;
      if ({issued_count, add_issue_dest, mul_issue_dest} !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_counts: got cnt=%0d ad=%0d md=%0d expected 0", issued_count, add_issue_dest, mul_issue_dest);
      end
      $display("test_reset done");
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      drive(1'b1, pack_inst(OP_ADD, 8'd5, 8'd3, 8'd4), 1'b1, pack_inst(OP_ADD, 8'd8, 8'd6, 8'd7));
      tick();
      drive(1'b1, pack_inst(OP_ADD, 8'd9, 8'd1, 8'd2), 1'b0, '0);
      tick();
      idle();
      vectors++;
      if ({add_issue_valid, add_issue_dest, select_instruction} !== {1'b1, 8'd5, SEL_ONE}) begin
         miscompares++;
         $display("FAIL mid_three_buffered: got av=%b ad=%0d sel=%b expected 1 5 01", add_issue_valid, add_issue_dest, select_instruction);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({add_issue_valid, mul_issue_valid, select_instruction} !== 4'b0) begin
         miscompares++;
         $display("FAIL mid_async_reset: got av=%b mv=%b sel=%b expected 0 0 00", add_issue_valid, mul_issue_valid, select_instruction);
      end
      tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({select_instruction, add_issue_valid, mul_issue_valid, issued_count} !== {SEL_TWO, 2'b00, 16'd0}) begin
         miscompares++;
         $display("FAIL mid_after_release: got sel=%b av=%b mv=%b cnt=%0d expected 10 0 0 0",
                  select_instruction, add_issue_valid, mul_issue_valid, issued_count);
      end
      $display("test_reset_mid_stream done");
   endtask

   task automatic test_dual_issue();
      do_reset();
      add_issue_ready = 1'b1;
      mul_issue_ready = 1'b1;
      drive(1'b1, pack_inst(OP_MUL, 8'd2, 8'd0, 8'd1), 1'b1, pack_inst(OP_ADD, 8'd5, 8'd3, 8'd4));
      tick();
      idle();
      vectors++;
      if ({mul_issue_valid, mul_issue_dest, mul_issue_src1, mul_issue_src2} !== {1'b1, 8'd2, 8'd0, 8'd1}) begin
         miscompares++;
         $display("FAIL dual_mul_port: got v=%b %0d,%0d,%0d expected 1 2,0,1", mul_issue_valid, mul_issue_dest, mul_issue_src1, mul_issue_src2);
      end
      vectors++;
      if ({add_issue_valid, add_issue_dest, add_issue_src1, add_issue_src2} !== {1'b1, 8'd5, 8'd3, 8'd4}) begin
         miscompares++;
         $display("FAIL dual_add_port: got v=%b %0d,%0d,%0d expected 1 5,3,4", add_issue_valid, add_issue_dest, add_issue_src1, add_issue_src2);
      end
      vectors++;
      if (select_instruction !== SEL_TWO) begin
         miscompares++;
         $display("FAIL dual_select: got %b expected 10", select_instruction);
      end
      tick();
      vectors++;
      if ({issued_count, add_issue_valid, mul_issue_valid, select_instruction} !== {16'd2, 2'b00, SEL_TWO}) begin
         miscompares++;
         $display("FAIL dual_after: got cnt=%0d av=%b mv=%b sel=%b expected 2 0 0 10",
                  issued_count, add_issue_valid, mul_issue_valid, select_instruction);
      end
      $display("test_dual_issue done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      add_issue_ready = 1'b1;
      mul_issue_ready = 1'b1;
      drive(1'b1, pack_inst(OP_ADD, 8'd5, 8'd3, 8'd4), 1'b1, pack_inst(OP_ADD, 8'd8, 8'd6, 8'd7));
      tick();
      idle();
      vectors++;
      if ({add_issue_valid, add_issue_dest, mul_issue_valid} !== {1'b1, 8'd5, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_first: got av=%b ad=%0d mv=%b expected 1 5 0", add_issue_valid, add_issue_dest, mul_issue_valid);
      end
      tick();
      vectors++;
      if ({add_issue_valid, add_issue_dest, issued_count} !== {1'b1, 8'd8, 16'd1}) begin
         miscompares++;
         $display("FAIL b2b_second: got av=%b ad=%0d cnt=%0d expected 1 8 1", add_issue_valid, add_issue_dest, issued_count);
      end
      tick();
      vectors++;
      if ({add_issue_valid, issued_count} !== {1'b0, 16'd2}) begin
         miscompares++;
         $display("FAIL b2b_drained: got av=%b cnt=%0d expected 0 2", add_issue_valid, issued_count);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_stall();
      do_reset();
      add_issue_ready = 1'b1;
      mul_issue_ready = 1'b0;
      drive(1'b1, pack_inst(OP_MUL, 8'd9, 8'd1, 8'd2), 1'b1, pack_inst(OP_ADD, 8'd10, 8'd3, 8'd4));
      tick();
      drive(1'b1, pack_inst(OP_ADD, 8'd11, 8'd5, 8'd6), 1'b1, pack_inst(OP_ADD, 8'd12, 8'd7, 8'd8));
      vectors++;
      if ({select_instruction, mul_issue_valid, mul_issue_dest, add_issue_valid} !== {SEL_TWO, 1'b1, 8'd9, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_first: got sel=%b mv=%b md=%0d av=%b expected 10 1 9 0",
                  select_instruction, mul_issue_valid, mul_issue_dest, add_issue_valid);
      end
      tick();
      idle();
      vectors++;
      if ({select_instruction, overflow_err, add_issue_valid, mul_issue_valid} !== {SEL_NONE, 3'b001}) begin
         miscompares++;
         $display("FAIL stall_full: got sel=%b ovf=%b av=%b mv=%b expected 00 0 0 1",
                  select_instruction, overflow_err, add_issue_valid, mul_issue_valid);
      end
      tick();
      vectors++;
      if ({add_issue_valid, issued_count} !== {1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL stall_hold: got av=%b cnt=%0d expected 0 0", add_issue_valid, issued_count);
      end
      mul_issue_ready = 1'b1;
      #1;
      vectors++;
      if ({add_issue_valid, add_issue_dest, mul_issue_dest} !== {1'b1, 8'd10, 8'd9}) begin
         miscompares++;
         $display("FAIL stall_release_pair: got av=%b ad=%0d md=%0d expected 1 10 9", add_issue_valid, add_issue_dest, mul_issue_dest);
      end
      tick();
      vectors++;
      if ({issued_count, add_issue_valid, add_issue_dest, mul_issue_valid, select_instruction} !== {16'd2, 1'b1, 8'd11, 1'b0, SEL_TWO}) begin
         miscompares++;
         $display("FAIL stall_after_pair: got cnt=%0d av=%b ad=%0d mv=%b sel=%b expected 2 1 11 0 10",
                  issued_count, add_issue_valid, add_issue_dest, mul_issue_valid, select_instruction);
      end
      tick();
      vectors++;
      if ({issued_count, add_issue_dest} !== {16'd3, 8'd12}) begin
         miscompares++;
         $display("FAIL stall_in_order: got cnt=%0d ad=%0d expected 3 12", issued_count, add_issue_dest);
      end
      tick();
      $display("test_stall done");
   endtask

   task automatic test_illegal();
      do_reset();
      add_issue_ready = 1'b1;
      mul_issue_ready = 1'b1;
      drive(1'b1, pack_inst(8'hFF, 8'd1, 8'd2, 8'd3), 1'b1, pack_inst(OP_ADD, 8'd5, 8'd3, 8'd4));
      tick();
      idle();
      vectors++;
      if ({add_issue_valid, mul_issue_valid, illegal_op} !== 3'b000) begin
         miscompares++;
         $display("FAIL ill_at_head: got av=%b mv=%b ill=%b expected 0 0 0", add_issue_valid, mul_issue_valid, illegal_op);
      end
      tick();
      vectors++;
      if ({illegal_op, add_issue_valid, add_issue_dest, issued_count} !== {2'b11, 8'd5, 16'd0}) begin
         miscompares++;
         $display("FAIL ill_pulse: got ill=%b av=%b ad=%0d cnt=%0d expected 1 1 5 0",
                  illegal_op, add_issue_valid, add_issue_dest, issued_count);
      end
      tick();
      vectors++;
      if ({illegal_op, add_issue_valid, issued_count} !== {2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL ill_after: got ill=%b av=%b cnt=%0d expected 0 0 1", illegal_op, add_issue_valid, issued_count);
      end
      $display("test_illegal done");
   endtask

   task automatic test_overflow();
      do_reset();
      drive(1'b1, pack_inst(OP_ADD, 8'd1, 8'd0, 8'd0), 1'b1, pack_inst(OP_ADD, 8'd2, 8'd0, 8'd0));
      tick();
      drive(1'b1, pack_inst(OP_ADD, 8'd3, 8'd0, 8'd0), 1'b1, pack_inst(OP_ADD, 8'd4, 8'd0, 8'd0));
      tick();
      vectors++;
      if ({select_instruction, overflow_err} !== {SEL_NONE, 1'b0}) begin
         miscompares++;
         $display("FAIL ovf_full: got sel=%b ovf=%b expected 00 0", select_instruction, overflow_err);
      end
      drive(1'b1, pack_inst(OP_ADD, 8'd20, 8'd0, 8'd0), 1'b1, pack_inst(OP_MUL, 8'd21, 8'd0, 8'd0));
      tick();
      idle();
      vectors++;
      if ({overflow_err, add_issue_valid, add_issue_dest, mul_issue_valid} !== {2'b11, 8'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL ovf_set: got ovf=%b av=%b ad=%0d mv=%b expected 1 1 1 0",
                  overflow_err, add_issue_valid, add_issue_dest, mul_issue_valid);
      end
      tick();
      add_issue_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         vectors++;
         if ({overflow_err, add_issue_valid, add_issue_dest} !== {2'b11, 8'(k)}) begin
            miscompares++;
            $display("FAIL ovf_drain_%0d: got ovf=%b av=%b ad=%0d expected 1 1 %0d", k, overflow_err, add_issue_valid, add_issue_dest, k);
         end
         tick();
      end
      vectors++;
      if ({overflow_err, add_issue_valid, mul_issue_valid, issued_count} !== {3'b100, 16'd4}) begin
         miscompares++;
         $display("FAIL ovf_empty: got ovf=%b av=%b mv=%b cnt=%0d expected 1 0 0 4",
                  overflow_err, add_issue_valid, mul_issue_valid, issued_count);
      end
      $display("test_overflow done");
   endtask

   initial begin
      test_reset();
      rst_n = 1'b1;
      test_reset_mid_stream();
      test_dual_issue();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_overflow();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
